// File: rtl/program_store.sv
// program_store: multi-slot program memory with a registered fetch port and a
// byte-stream loader that rewrites one slot at a time.
module program_store #(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned SLOTS  = 4,
  parameter int unsigned SLOT_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic [SLOT_W-1:0] slot,
  input  logic [PC_W-1:0]   pc,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              ld_start,
  input  logic [SLOT_W-1:0] ld_slot,
  input  logic [PC_W:0]     ld_len,
  input  logic [7:0]        ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_err,
  output logic [7:0]        ld_sum
);

  localparam int unsigned LEN_W = PC_W + 1;
  localparam int unsigned DW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_e;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [PC_W-1:0]     addr_q, addr_d;
  logic [7:0]          op_q, op_d;
  logic [7:0]          sum_q, sum_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [15:0]         instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                we_c;
  logic                fetch_slot_ok_c;
  logic                ld_slot_ok_c;

  // Loaded words; loaded_q marks words overwritten since power-up, otherwise
  // the standard wash program image is returned. Neither is touched by reset.
  logic [15:0] mem_q    [SLOTS][DEPTH];
  logic        loaded_q [SLOTS][DEPTH];

  // Standard wash program held in slot 0 at power-up
  function automatic logic [15:0] boot_word(input logic [SLOT_W-1:0] s,
                                            input logic [PC_W-1:0]   a);
    logic [15:0] w;
    w = 16'h0000;
    if (s == '0) begin
      case (a)
        PC_W'(2):  w = 16'h6402;
        PC_W'(3):  w = 16'h3201;
        PC_W'(4):  w = 16'h0511;
        PC_W'(5):  w = 16'h1404;
        PC_W'(6):  w = 16'h0A01;
        PC_W'(7):  w = 16'h1405;
        PC_W'(8):  w = 16'h0A01;
        PC_W'(9):  w = 16'h0012;
        PC_W'(10): w = 16'h0522;
        PC_W'(11): w = 16'h6403;
        default:   w = 16'h0000;
      endcase
    end
    return w;
  endfunction

  // Slot range checks collapse to constants when SLOTS fills the index width
  if (SLOTS == (1 << SLOT_W)) begin : g_slot_full
    assign fetch_slot_ok_c = 1'b1;
    assign ld_slot_ok_c    = 1'b1;
  end else begin : g_slot_part
    assign fetch_slot_ok_c = (32'(slot) < SLOTS);
    assign ld_slot_ok_c    = (32'(ld_slot) < SLOTS);
  end

  // Fetch port: out-of-range addresses and the slot under load read as halt
  always_comb begin
    instr_d       = instr_q;
    instr_valid_d = fetch_en;
    if (fetch_en) begin
      if ((32'(pc) < DEPTH) && fetch_slot_ok_c && !(busy_q && (slot == slot_q))) begin
        instr_d = loaded_q[slot][DW'(pc)] ? mem_q[slot][DW'(pc)] : boot_word(slot, pc);
      end else begin
        instr_d = 16'h0000;
      end
    end
  end

  // Loader next-state: opcode byte then operand byte per instruction
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    len_d   = len_q;
    addr_d  = addr_q;
    op_d    = op_q;
    sum_d   = sum_q;
    err_d   = err_q;
    done_d  = 1'b0;
    we_c    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          if ((ld_len == '0) || (32'(ld_len) > DEPTH) || !ld_slot_ok_c) begin
            err_d = 1'b1;
          end else begin
            slot_d  = ld_slot;
            len_d   = ld_len;
            addr_d  = '0;
            sum_d   = '0;
            err_d   = 1'b0;
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (ld_start) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (ld_valid) begin
          op_d    = ld_data;
          sum_d   = sum_q + ld_data;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (ld_start) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (ld_valid) begin
          we_c  = 1'b1;
          sum_d = sum_q + ld_data;
          if ({1'b0, addr_q} == (len_q - LEN_W'(1))) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + PC_W'(1);
            state_d = S_LO;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      slot_q        <= '0;
      len_q         <= '0;
      addr_q        <= '0;
      op_q          <= '0;
      sum_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      len_q         <= len_d;
      addr_q        <= addr_d;
      op_q          <= op_d;
      sum_q         <= sum_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Program storage write port
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem_q[slot_q][DW'(addr_q)]    <= {ld_data, op_q};
      loaded_q[slot_q][DW'(addr_q)] <= 1'b1;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign ld_ready    = busy_q;
  assign ld_busy     = busy_q;
  assign ld_done     = done_q;
  assign ld_err      = err_q;
  assign ld_sum      = sum_q;

endmodule

// File: tb/tb_program_store.sv
// Bench for program_store: scoreboarded fetches against a word-array model,
// loader flags checked cycle by cycle.
module tb_program_store;

  localparam int unsigned PC_W   = 8;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned SLOTS  = 4;
  localparam int unsigned SLOT_W = 2;

  localparam logic [15:0] BOOT [10] = '{16'h6402, 16'h3201, 16'h0511, 16'h1404, 16'h0A01,
                                        16'h1405, 16'h0A01, 16'h0012, 16'h0522, 16'h6403};

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_en;
  logic [SLOT_W-1:0] slot;
  logic [PC_W-1:0]   pc;
  logic [15:0]       instr;
  logic              instr_valid;
  logic              ld_start;
  logic [SLOT_W-1:0] ld_slot;
  logic [PC_W:0]     ld_len;
  logic [7:0]        ld_data;
  logic              ld_valid;
  logic              ld_ready;
  logic              ld_busy;
  logic              ld_done;
  logic              ld_err;
  logic [7:0]        ld_sum;

  program_store #(.PC_W(PC_W), .DEPTH(DEPTH), .SLOTS(SLOTS), .SLOT_W(SLOT_W)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .slot(slot), .pc(pc),
    .instr(instr), .instr_valid(instr_valid), .ld_start(ld_start), .ld_slot(ld_slot),
    .ld_len(ld_len), .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err), .ld_sum(ld_sum)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  // Reference model: program words per slot plus the loader's visible state
  logic [15:0] m_mem [SLOTS][DEPTH];
  bit          m_busy;
  int          m_slot;
  bit          m_err;
  logic [7:0]  m_sum;

  logic [15:0] exp_q[$];
  logic [10:0] fetch_plan[$];
  logic [7:0]  tx_bytes[$];
  logic [15:0] last_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_fetch(input int s, input int p);
    if (p >= int'(DEPTH) || s >= int'(SLOTS)) return 16'h0000;
    if (m_busy && s == m_slot) return 16'h0000;
    return m_mem[s][p];
  endfunction

  // Monitor: every instr_valid cycle consumes one expected word; otherwise instr must hold
  always @(negedge clk) begin
    if (!rst_n) begin
      check("instr_in_reset", 32'(instr), 32'h0);
      last_exp = 16'h0000;
    end else if (instr_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL fetch_unexpected: got instr_valid with instr 0x%0h, expected none", instr);
      end else begin
        last_exp = exp_q.pop_front();
        check("fetch", 32'(instr), 32'(last_exp));
      end
    end else begin
      check("instr_hold", 32'(instr), 32'(last_exp));
    end
  end

  task automatic step(input bit fe, input int s, input int p);
    fetch_en = fe;
    slot     = SLOT_W'(s);
    pc       = PC_W'(p);
    if (fe) exp_q.push_back(model_fetch(s, p));
    @(posedge clk);
    #1;
    fetch_en = 1'b0;
  endtask

  task automatic step_bg();
    logic [10:0] f;
    if (fetch_plan.size() > 0) f = fetch_plan.pop_front();
    else f = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 70))};
    step(f[10], int'(f[9:8]), int'(f[7:0]));
  endtask

  task automatic check_flags(input string ctx, input bit done_exp);
    check({ctx, "_busy"},  32'(ld_busy),  32'(m_busy));
    check({ctx, "_ready"}, 32'(ld_ready), 32'(m_busy));
    check({ctx, "_done"},  32'(ld_done),  32'(done_exp));
    check({ctx, "_err"},   32'(ld_err),   32'(m_err));
    check({ctx, "_sum"},   32'(ld_sum),   32'(m_sum));
  endtask

  // One load: gap_mode 0 back-to-back, 1 alternating idle cycles, 2 random idles.
  // stop_at >= 0 interrupts before that byte, by ld_start or (use_rst) by reset.
  task automatic do_load(input int s, input int len, input int gap_mode,
                         input int stop_at, input bit use_rst);
    bit         ok;
    logic [7:0] lo;
    logic [7:0] b;
    ok       = (len >= 1 && len <= int'(DEPTH) && s < int'(SLOTS));
    ld_start = 1'b1;
    ld_slot  = SLOT_W'(s);
    ld_len   = (PC_W + 1)'(len);
    step_bg();
    ld_start = 1'b0;
    if (ok) begin
      m_busy = 1'b1; m_slot = s; m_sum = 8'h00; m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    check_flags("start", 1'b0);
    if (!ok) return;
    lo = 8'h00;
    for (int i = 0; i < 2 * len; i++) begin
      if (i == stop_at) begin
        if (use_rst) begin
          rst_n = 1'b0;
          #1;
          m_busy = 1'b0; m_err = 1'b0; m_sum = 8'h00;
          exp_q.delete();
          check_flags("reset_midload", 1'b0);
          check("reset_instr_valid", 32'(instr_valid), 32'h0);
          @(posedge clk);
          #1;
          rst_n = 1'b1;
        end else begin
          ld_start = 1'b1;
          ld_slot  = SLOT_W'($urandom_range(0, 3));
          ld_len   = (PC_W + 1)'($urandom_range(1, 64));
          step_bg();
          ld_start = 1'b0;
          m_busy = 1'b0; m_err = 1'b1;
          check_flags("abort", 1'b0);
        end
        return;
      end
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
        ld_valid = 1'b0;
        step_bg();
        check_flags("gap", 1'b0);
      end
      b = (tx_bytes.size() > 0) ? tx_bytes.pop_front() : 8'($urandom);
      ld_valid = 1'b1;
      ld_data  = b;
      step_bg();
      ld_valid = 1'b0;
      m_sum = m_sum + b;
      if (i % 2 == 0) begin
        lo = b;
      end else begin
        m_mem[s][i / 2] = {b, lo};
        if (i == 2 * len - 1) m_busy = 1'b0;
      end
      check_flags("byte", i == 2 * len - 1);
    end
  endtask

  initial begin
    for (int s = 0; s < int'(SLOTS); s++)
      for (int a = 0; a < int'(DEPTH); a++) m_mem[s][a] = 16'h0000;
    for (int i = 0; i < 10; i++) m_mem[0][i + 2] = BOOT[i];
    m_busy = 1'b0; m_slot = 0; m_err = 1'b0; m_sum = 8'h00;
    last_exp = 16'h0000;

    rst_n = 1'b0; fetch_en = 1'b1; slot = '0; pc = PC_W'(2);
    ld_start = 1'b0; ld_slot = '0; ld_len = '0; ld_data = '0; ld_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_flags("reset", 1'b0);
    check("reset_instr", 32'(instr), 32'h0);
    check("reset_instr_valid", 32'(instr_valid), 32'h0);
    fetch_en = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 0, 0);

    // Standard program, one past its end, and the first out-of-range pc
    for (int p = 2; p <= 12; p++) step(1'b1, 0, p);
    step(1'b1, 0, 64);
    step(1'b1, 3, 255);
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);

    // Back-to-back load of slot 1, fetches of the locked slot and slot 0 alongside
    tx_bytes = '{8'h04, 8'h14, 8'h01, 8'h0A};
    fetch_plan = '{{1'b1, 2'd1, 8'd0}, {1'b1, 2'd1, 8'd0}, {1'b1, 2'd0, 8'd2},
                   {1'b1, 2'd1, 8'd0}, {1'b1, 2'd0, 8'd2}};
    do_load(1, 2, 0, -1, 1'b0);
    check("load1_sum_const", 32'(ld_sum), 32'h23);
    step(1'b1, 1, 0);
    step(1'b1, 1, 1);
    check("load1_done_cleared", 32'(ld_done), 32'h0);

    // Rejected starts leave the loader idle
    do_load(1, 0, 0, -1, 1'b0);
    do_load(1, 65, 0, -1, 1'b0);
    check("bad_start_err_const", 32'(ld_err), 32'h1);

    // Abort after three bytes: word 0 written, word 1 untouched
    fetch_plan = '{{1'b1, 2'd2, 8'd0}};
    do_load(2, 4, 0, 3, 1'b0);
    step(1'b0, 0, 0);
    check("abort_no_done", 32'(ld_done), 32'h0);
    step(1'b1, 2, 0);
    step(1'b1, 2, 1);

    // Alternating-valid reload of slot 1 with same-pc fetches of slot 0
    tx_bytes = '{8'h04, 8'h14, 8'h01, 8'h0A};
    fetch_plan = '{{1'b1, 2'd1, 8'd0}, {1'b1, 2'd1, 8'd0}, {1'b1, 2'd0, 8'd0},
                   {1'b1, 2'd1, 8'd1}, {1'b1, 2'd0, 8'd0}, {1'b1, 2'd0, 8'd1},
                   {1'b1, 2'd1, 8'd0}, {1'b1, 2'd0, 8'd2}, {1'b1, 2'd0, 8'd1}};
    do_load(1, 2, 1, -1, 1'b0);
    check("load_gap_sum_const", 32'(ld_sum), 32'h23);
    step(1'b1, 1, 0);
    step(1'b1, 1, 1);

    // Reset mid-load, partial words survive, then a full load completes
    do_load(1, 4, 0, 5, 1'b1);
    for (int p = 0; p < 4; p++) step(1'b1, 1, p);
    do_load(3, 3, 0, -1, 1'b0);
    for (int p = 0; p < 4; p++) step(1'b1, 3, p);

    // Randomised loads, including a full-depth one and overwriting slot 0
    do_load(2, 64, 2, -1, 1'b0);
    do_load(0, $urandom_range(1, 12), 2, -1, 1'b0);
    for (int k = 0; k < 6; k++)
      do_load($urandom_range(0, 3), $urandom_range(1, 64), 2, -1, 1'b0);
    for (int k = 0; k < 150; k++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 70));
    step(1'b1, 2, 63);
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/program_store.md
# program_store

Multi-slot, field-loadable program memory for the washing register machine, replacing the fixed instruction ROM. It holds SLOTS independent wash programs of DEPTH 16-bit instructions each. The sequencer fetches through a registered read port. A byte-stream loader writes new programs into any slot at run time. Slot 0 powers up holding the standard wash program.

## Interface
- PC_W, 8: program-counter width.
- DEPTH, 64: instructions per slot, 1..2^PC_W.
- SLOTS, 4: number of program slots, at least 2.
- SLOT_W, 2: slot-index width, equal to clog2(SLOTS).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  fetch request.
- slot  in  SLOT_W  slot to fetch from.
- pc  in  PC_W  instruction address within the slot.
- instr  out  16  registered instruction {operand[15:8], opcode[7:0]}.
- instr_valid  out  1  instr was updated by a fetch on the previous cycle.
- ld_start  in  1  one-cycle pulse that begins a load.
- ld_slot  in  SLOT_W  target slot, sampled on ld_start.
- ld_len  in  PC_W+1  instruction count to load, sampled on ld_start.
- ld_data  in  8  load byte.
- ld_valid  in  1  ld_data is valid.
- ld_ready  out  1  loader accepts a byte this cycle.
- ld_busy  out  1  a load is in progress.
- ld_done  out  1  one-cycle pulse when a load completes.
- ld_err  out  1  sticky error flag, cleared by the next accepted ld_start.
- ld_sum  out  8  running mod-256 sum of the accepted bytes.

## Operation
- Storage: SLOTS×DEPTH words of 16 bits. The memory is NOT cleared by reset.
- Power-up contents: every word is 0x0000 (halt), except slot 0 at addresses 2..11:
  - 0x6402 fill 100, 0x3201 wait 50, 0x0511 set 5
  - 0x1404 forward 20, 0x0A01 wait 10, 0x1405 reverse 20, 0x0A01 wait 10
  - 0x0012 dec, 0x0522 jnz 5, 0x6403 release 100
- Opcode map: halt 00, wait 01, fill 02, release 03, forward 04, reverse 05, set 11, dec 12, jz 21, jnz 22. The block stores words and does not decode them.
- Fetch:
  - When fetch_en=1, instr <= mem[slot][pc].
  - Returns 0x0000 if pc >= DEPTH, slot >= SLOTS, or ld_busy=1 and slot equals the latched load slot.
  - When fetch_en=0, instr holds its value.
- Loader FSM states: IDLE, LO, HI.
- IDLE:
  - ld_ready=0.
  - On ld_start: if ld_len is 0, ld_len > DEPTH, or ld_slot >= SLOTS, set ld_err=1 and stay in IDLE.
  - Otherwise latch slot and len, clear addr, ld_sum and ld_err, and go to LO.
- LO: ld_ready=1. On ld_valid, latch the byte as the opcode, add it to ld_sum, and go to HI.
- HI: ld_ready=1. On ld_valid:
  - write {ld_data, opcode} to mem[slot][addr] and add ld_data to ld_sum;
  - if addr = len-1, go to IDLE and pulse ld_done;
  - otherwise addr+1 and go to LO.
- ld_start in LO or HI aborts the load: ld_err=1, go to IDLE, no ld_done. Words already written remain. The start pulse itself is not taken as a new load.
- ld_busy = (state != IDLE). The slot being loaded is unlocked when ld_busy falls.
- ld_sum wraps modulo 256 and holds its value after ld_done or an abort.

## Timing
- Reset values: instr=0x0000, instr_valid=0, ld_ready=0, ld_busy=0, ld_done=0, ld_err=0, ld_sum=0x00, FSM in IDLE.
- Fetch latency is 1 cycle: pc, slot and fetch_en sampled at edge N appear on instr at edge N. instr_valid is fetch_en delayed by 1 cycle.
- Byte handshake: a byte transfers on an edge where ld_valid=1 and ld_ready=1.
  - The loader sustains 1 byte per cycle, i.e. 2 cycles per instruction.
  - ld_valid may drop between bytes with no loss.
- ld_busy and ld_ready rise on the edge after an accepted ld_start.
- On the final HI transfer edge: the word is written, and ld_busy falls while ld_done=1 in the same cycle.
- A fetch of the loaded slot issued in the cycle after ld_done returns the new data.
- Reset mid-load: the FSM returns to IDLE immediately and all flags clear. Partially written words remain in memory.
- A fetch from an unlocked slot during a load is unaffected, including when both ports access the same pc.

## Test plan
- Reset, then fetch slot 0 at pc 2..12 with fetch_en=1 → instr sequence 0x6402, 0x3201, 0x0511, 0x1404, 0x0A01, 0x1405, 0x0A01, 0x0012, 0x0522, 0x6403, 0x0000. Each word arrives 1 cycle after its pc. instr=0x0000 while rst_n=0. pc=64 → 0x0000.
- Load slot 1 with ld_len=2 and bytes 04, 14, 01, 0A sent back-to-back → ld_done pulses with the 4th byte and ld_sum=0x23. Fetch slot 1 pc 0/1 → 0x1404 / 0x0A01.
- During the slot 1 load, fetch slot 1 pc 0 → 0x0000. Fetch slot 0 pc 2 → 0x6402.
- ld_start with ld_len=0 or ld_len=65 → ld_err=1, ld_busy stays 0. A following valid ld_start clears ld_err.
- Abort a load with ld_start after 3 bytes → ld_err=1, ld_busy=0 next cycle, no ld_done. Word 0 is written and word 1 is not.
- Load with ld_valid toggling every other cycle → same words and ld_sum as the back-to-back case. Assert rst_n mid-load → ld_busy=0 and ld_ready=0 at once. A new load then completes normally.
